ram_burst_reader: RTL and testbench

- Read-side initiator for the 6-bank, 12-word burst RAM.
- Accepts a job (base address, window count) and drives the RAM's en/addr_in request, then waits for the ready pulse.
- Captures the 12 parallel 64-bit words into a local buffer and serializes them onto a valid/ready stream for the downstream datapath.
- Repeats per window, advancing the address by WIN_STEP modulo 512.

---
 rtl/ram_rd_pkg.sv | 23 ++
 rtl/ram_window_buf.sv | 35 +++
 rtl/ram_burst_reader.sv | 158 +++++++++++++++
 tb/tb_ram_burst_reader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_rd_pkg.sv
// Shared constants and state encoding for the burst RAM read initiator.
// Imported by ram_window_buf and ram_burst_reader.
package ram_rd_pkg;

  localparam int WIN_WORDS  = 12;
  localparam int IDX_W      = 4;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_STREAM,
    ST_FIN
  } state_t;

  // Width of the RAM's flattened 12-word output bus.
  function automatic int bus_w(int data_w);
    return WIN_WORDS * data_w;
  endfunction

endpackage

// File: rtl/ram_window_buf.sv
// Twelve-word window buffer: parallel load from the RAM output bus,
// single indexed read port (out-of-range index reads as zero).
module ram_window_buf
  import ram_rd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [bus_w(DATA_W)-1:0] load_data,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [WIN_WORDS];

  // NOTE: this register file is small and the reader must come out of reset
  // fully defined, so it gets an explicit reset; large RAM arrays would not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < WIN_WORDS; k++) mem[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < WIN_WORDS; k++) mem[k] <= load_data[DATA_W*k +: DATA_W];
    end
  end

  // NOTE: default assignment first so no path through this block leaves
  // rd_data unassigned, which would infer a latch.
  always_comb begin
    rd_data = '0;
    if (rd_idx < IDX_W'(WIN_WORDS)) rd_data = mem[rd_idx];
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Read-side initiator for the 6-bank, 12-word burst RAM: fetches windows and
// streams them out on valid/ready. Optional watchdog: define RD_TIMEOUT_EN.
module ram_burst_reader
  import ram_rd_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WIN_STEP = 12
`ifdef RD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [7:0]               num_windows,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     ram_en,
  output logic                     ram_wren,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic                     ram_ready,
  input  logic [bus_w(DATA_W)-1:0] ram_data,
  output logic                     m_valid,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_last,
  input  logic                     m_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_WORDS - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  nxt_idx;
  logic [7:0]        win_left;
  logic              last_win;
  logic              buf_load;
  logic [DATA_W-1:0] buf_rd;

  assign ram_wren = 1'b0;
  assign nxt_idx  = idx + IDX_W'(1);
  assign last_win = (win_left == 8'd1);
  assign buf_load = (state == ST_WAIT) && ram_ready;

  // The buffer is read one index ahead so m_data can be registered.
  ram_window_buf #(.DATA_W(DATA_W)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .load_data(ram_data),
    .rd_idx   (nxt_idx),
    .rd_data  (buf_rd)
  );

`ifdef RD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] wait_cnt;
`else
  assign error = 1'b0;
`endif

  // NOTE: every register here is sequential state, so all assignments are
  // non-blocking; blocking ones would race against other clocked readers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ram_en   <= 1'b0;
      ram_addr <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      idx      <= '0;
      win_left <= '0;
`ifdef RD_TIMEOUT_EN
      error    <= 1'b0;
      wait_cnt <= '0;
`endif
    end else begin
      ram_en <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
`ifdef RD_TIMEOUT_EN
            error <= 1'b0;
`endif
            if (num_windows != 8'd0) begin
              busy     <= 1'b1;
              ram_addr <= base_addr;
              win_left <= num_windows;
              ram_en   <= 1'b1;
              state    <= ST_REQ;
            end else begin
              done  <= 1'b1;
              state <= ST_FIN;
            end
          end
        end
        ST_REQ: begin
`ifdef RD_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ram_ready) begin
            m_valid <= 1'b1;
            m_data  <= ram_data[DATA_W-1:0];
            m_last  <= 1'b0;
            idx     <= '0;
            state   <= ST_STREAM;
          end
`ifdef RD_TIMEOUT_EN
          // Abandon the job; the partial window is never streamed.
          else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
`endif
        end
        ST_STREAM: begin
          if (m_ready) begin
            if (idx == LAST_IDX) begin
              m_valid <= 1'b0;
              m_data  <= '0;
              m_last  <= 1'b0;
              if (last_win) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= ST_FIN;
              end else begin
                win_left <= win_left - 8'd1;
                ram_addr <= ram_addr + ADDR_W'(WIN_STEP);
                ram_en   <= 1'b1;
                state    <= ST_REQ;
              end
            end else begin
              idx    <= nxt_idx;
              m_data <= buf_rd;
              m_last <= (nxt_idx == LAST_IDX) && last_win;
            end
          end
        end
        ST_FIN: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Randomised bench for ram_burst_reader: a RAM responder with fixed latency,
// a stream monitor and a window-level reference model of expected traffic.
module tb_ram_burst_reader;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 64;
  localparam int WW      = 12;
  localparam int RAM_LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        num_windows;
  logic              busy, done, error, ram_en, ram_wren;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ready;
  logic [WW*DATA_W-1:0] ram_data;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;

  ram_burst_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_windows(num_windows), .busy(busy), .done(done), .error(error),
    .ram_en(ram_en), .ram_wren(ram_wren), .ram_addr(ram_addr),
    .ram_ready(ram_ready), .ram_data(ram_data), .m_valid(m_valid),
    .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [DATA_W-1:0] mem [512];
  int cyc = 0;
  int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random
  bit withhold = 1'b0;

  // Monitor state, written only by the negedge monitor (cleared by clear_mon).
  logic [ADDR_W-1:0] en_addr_q[$];
  int                en_cyc_q[$];
  int                rise_cyc_q[$];
  logic [DATA_W-1:0] beat_q[$];
  bit                last_q[$];
  int                beat_cyc_q[$];
  int  done_cnt, done_cyc, stall_err;
  bit  wren_seen, en_double, busy_seen, valid_seen, busy_at_done;
  bit  prev_en, prev_valid, prev_stall, prev_last;
  logic [DATA_W-1:0] prev_data;
  bit  ram_pend = 1'b0;
  int  ready_cyc;
  logic [ADDR_W-1:0] pend_addr;

  task automatic clear_mon();
    en_addr_q.delete(); en_cyc_q.delete(); rise_cyc_q.delete();
    beat_q.delete(); last_q.delete(); beat_cyc_q.delete();
    done_cnt = 0; done_cyc = -1; stall_err = 0;
    wren_seen = 0; en_double = 0; busy_seen = 0; valid_seen = 0; busy_at_done = 0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Mid-cycle monitor: all DUT outputs and bench inputs are settled here.
  initial forever begin
    @(negedge clk);
    if (ram_wren) wren_seen = 1;
    if (busy) busy_seen = 1;
    if (m_valid) valid_seen = 1;
    if (ram_en) begin
      if (prev_en) en_double = 1;
      en_addr_q.push_back(ram_addr);
      en_cyc_q.push_back(cyc);
      if (!withhold) begin
        ram_pend  = 1;
        ready_cyc = cyc + RAM_LAT;
        pend_addr = ram_addr;
      end
    end
    if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stall_err++;
    if (m_valid && !prev_valid) rise_cyc_q.push_back(cyc);
    if (m_valid && m_ready) begin
      beat_q.push_back(m_data);
      last_q.push_back(m_last);
      beat_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    prev_en    = ram_en;
    prev_valid = m_valid;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
  end

  // RAM responder: ready pulse RAM_LAT cycles after the ram_en cycle.
  initial forever begin
    @(posedge clk);
    #1;
    if (ram_pend && cyc == ready_cyc) begin
      for (int k = 0; k < WW; k++) ram_data[DATA_W*k +: DATA_W] = mem[9'(pend_addr + 9'(k))];
      ram_ready = 1'b1;
      ram_pend  = 0;
    end else begin
      ram_ready = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Launch one job, wait for its done, compare all traffic against the model.
  task automatic run_job(input string tag, input logic [ADDR_W-1:0] base,
                         input int n, input int mode, input bit mid_start);
    int st_cyc;
    logic [ADDR_W-1:0] exp_addr;
    int bad_data, bad_last, bad_addr, bad_time;
    rdy_mode = mode;
    clear_mon();
    @(posedge clk); #1;
    start = 1; base_addr = base; num_windows = 8'(n); st_cyc = cyc;
    @(posedge clk); #1;
    start = 0;
    check({tag, "_busy_after_start"}, busy, (n != 0));
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      if (mid_start && i == 20) begin
        start = 1; base_addr = ~base; num_windows = 8'd5;
      end else begin
        start = 0;
      end
    end
    start = 0;
    check({tag, "_done_seen"}, (done_cnt != 0), 1);
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_busy_at_done"}, busy_at_done, 0);
    check({tag, "_wren_low"}, wren_seen, 0);
`ifndef RD_TIMEOUT_EN
    check({tag, "_error_low"}, error, 0);
`endif
    if (n == 0) begin
      check({tag, "_zero_no_en"}, en_addr_q.size(), 0);
      check({tag, "_zero_no_busy"}, busy_seen, 0);
      check({tag, "_zero_done_cyc"}, done_cyc, st_cyc + 1);
      return;
    end
    check({tag, "_en_count"}, en_addr_q.size(), n);
    check({tag, "_beat_count"}, beat_q.size(), WW * n);
    check({tag, "_en_not_back_to_back"}, en_double, 0);
    check({tag, "_stall_stable"}, stall_err, 0);
    if (en_addr_q.size() != n || beat_q.size() != WW * n || rise_cyc_q.size() != n) return;
    bad_data = 0; bad_last = 0; bad_addr = 0; bad_time = 0;
    for (int w = 0; w < n; w++) begin
      exp_addr = 9'((int'(base) + w * 12) % 512);
      if (en_addr_q[w] !== exp_addr) begin
        bad_addr++;
        $display("FAIL %s_addr w%0d: got 0x%0h expected 0x%0h", tag, w, en_addr_q[w], exp_addr);
      end
      if (rise_cyc_q[w] != en_cyc_q[w] + RAM_LAT + 1) bad_time++;
      if (w > 0 && en_cyc_q[w] != beat_cyc_q[WW*w - 1] + 1) bad_time++;
      for (int k = 0; k < WW; k++) begin
        if (beat_q[WW*w + k] !== mem[9'(exp_addr + 9'(k))]) bad_data++;
        if (last_q[WW*w + k] != (w == n - 1 && k == WW - 1)) bad_last++;
      end
    end
    check({tag, "_addr_seq"}, bad_addr, 0);
    check({tag, "_beat_data"}, bad_data, 0);
    check({tag, "_last_flag"}, bad_last, 0);
    check({tag, "_window_timing"}, bad_time, 0);
    check({tag, "_done_after_last"}, done_cyc, beat_cyc_q[WW*n - 1] + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = {$urandom, $urandom};
    rst = 1; start = 0; base_addr = '0; num_windows = '0;
    ram_ready = 0; ram_data = '0; m_ready = 1;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {busy, done, error, ram_en, ram_wren, ram_addr, m_valid, m_last}, 0);
    check("reset_m_data", m_data, 0);
    @(negedge clk); rst = 0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ctrl", {busy, done, ram_en, m_valid}, 0);

    run_job("single", 9'h000, 1, 0, 0);
    run_job("wrap3", 9'h1FA, 3, 0, 0);
    run_job("backpressure", 9'h0A5, 1, 1, 0);
    run_job("zero", 9'h055, 0, 0, 0);
    run_job("mid_start", 9'h100, 2, 0, 1);

    // Asynchronous reset in the middle of a stream.
    rdy_mode = 0;
    clear_mon();
    @(posedge clk); #1;
    start = 1; base_addr = 9'h033; num_windows = 8'd2;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 500 && beat_q.size() < 5; i++) begin
      @(negedge clk); #1;
    end
    check("rst_reached_beat5", beat_q.size(), 5);
    rst = 1;
    #1;
    check("rst_async_ctrl", {busy, done, error, ram_en, ram_wren, ram_addr, m_valid, m_last}, 0);
    check("rst_async_m_data", m_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_done", done_cnt, 0);
    run_job("after_rst", 9'h1F0, 2, 0, 0);

`ifdef RD_TIMEOUT_EN
    withhold = 1;
    clear_mon();
    @(posedge clk); #1;
    start = 1; base_addr = 9'h010; num_windows = 8'd2;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 300 && done_cnt == 0; i++) @(posedge clk);
    #1;
    check("to_done_seen", done_cnt, 1);
    check("to_error_set", error, 1);
    check("to_no_valid", valid_seen, 0);
    if (en_cyc_q.size() > 0) check("to_done_cyc", done_cyc, en_cyc_q[0] + 65);
    withhold = 0;
    ram_pend = 0;
    run_job("to_recover", 9'h020, 1, 0, 0);
    check("to_error_cleared", error, 0);
`endif

    for (int j = 0; j < 6; j++) begin
      run_job($sformatf("rand%0d", j), 9'($urandom_range(0, 511)),
              $urandom_range(1, 4), $urandom_range(0, 2), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
